// File: rtl/sequenciador_pkg.sv
// Shared definitions for the servo position sequencer: FSM state codes,
// sweep endpoints and direction encodings.
package sequenciador_pkg;

   typedef enum logic [1:0] {
      PARADO   = 2'b00,
      CONTANDO = 2'b01,
      PASSO    = 2'b10
   } estado_t;

   localparam logic [2:0] POS_MIN = 3'd0;
   localparam logic [2:0] POS_MAX = 3'd7;

   localparam logic SENTIDO_SOBE  = 1'b0;
   localparam logic SENTIDO_DESCE = 1'b1;

endpackage

// File: rtl/sequenciador_posicao_servo_contador_m.sv
// Modulo-M up counter used as the sequencer dwell timer; fim flags the last
// count (Q == M-1) while zera gives a synchronous clear.
module contador_m #(
   parameter int unsigned M = 50_000_000,
   parameter int unsigned N = 26
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] Q,
   output logic         fim
);

   logic [N-1:0] contagem_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contagem_q <= '0;
      end else if (zera) begin
         contagem_q <= '0;
      end else if (conta) begin
         if (contagem_q == N'(M - 1)) contagem_q <= '0;
         else                         contagem_q <= contagem_q + 1'b1;
      end
   end

   assign Q   = contagem_q;
   assign fim = (contagem_q == N'(M - 1));

endmodule

// File: rtl/sequenciador_posicao_servo.sv
// Ping-pong 0..7..0 position sweep feeding controle_servo_3, one dwell per code.
// Optional manual override enabled by defining POSICAO_MANUAL_EN.
module sequenciador_posicao_servo
   import sequenciador_pkg::*;
#(
   parameter int unsigned TEMPO_POSICAO = 50_000_000,
   parameter int unsigned W_TIMER       = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       zerar,
`ifdef POSICAO_MANUAL_EN
   input  logic       manual,
   input  logic [2:0] posicao_manual,
`endif
   output logic [2:0] posicao,
   output logic       fim_posicao,
   output logic       db_sentido,
   output logic [1:0] db_estado
);

   estado_t      estado_q, estado_d;
   logic [2:0]   posicao_q, posicao_d;
   logic         sentido_q, sentido_d;
   logic         manual_ativo;
   logic [2:0]   posicao_manual_w;
   logic [W_TIMER-1:0] timer_w;
   logic         timer_fim;
   logic         timer_zera;

`ifdef POSICAO_MANUAL_EN
   assign manual_ativo     = manual;
   assign posicao_manual_w = posicao_manual;
`else
   assign manual_ativo     = 1'b0;
   assign posicao_manual_w = '0;
`endif

   // Counter terminates at TEMPO_POSICAO-2 so CONTANDO+PASSO spans exactly TEMPO_POSICAO cycles.
   assign timer_zera = zerar | manual_ativo | ~ligar | (estado_q != CONTANDO);

   contador_m #(
      .M (TEMPO_POSICAO - 1),
      .N (W_TIMER)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .zera  (timer_zera),
      .conta (estado_q == CONTANDO),
      .Q     (timer_w),
      .fim   (timer_fim)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= PARADO;
         posicao_q <= POS_MIN;
         sentido_q <= SENTIDO_SOBE;
      end else begin
         estado_q  <= estado_d;
         posicao_q <= posicao_d;
         sentido_q <= sentido_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      if (zerar) begin
         estado_d = ligar ? CONTANDO : PARADO;
      end else if (manual_ativo) begin
         estado_d = PARADO;
      end else begin
         case (estado_q)
            PARADO:   if (ligar) estado_d = CONTANDO;
            CONTANDO: begin
               if (!ligar)         estado_d = PARADO;
               else if (timer_fim) estado_d = PASSO;
            end
            PASSO:    estado_d = CONTANDO;
            default:  estado_d = PARADO;
         endcase
      end
   end

   always_comb begin
      posicao_d = posicao_q;
      sentido_d = sentido_q;
      if (zerar) begin
         posicao_d = POS_MIN;
         sentido_d = SENTIDO_SOBE;
      end else if (manual_ativo) begin
         posicao_d = posicao_manual_w;
         if (posicao_manual_w == POS_MAX)      sentido_d = SENTIDO_DESCE;
         else if (posicao_manual_w == POS_MIN) sentido_d = SENTIDO_SOBE;
      end else if (estado_q == PASSO) begin
         if (sentido_q == SENTIDO_SOBE) begin
            posicao_d = posicao_q + 3'd1;
            if (posicao_d == POS_MAX) sentido_d = SENTIDO_DESCE;
         end else begin
            posicao_d = posicao_q - 3'd1;
            if (posicao_d == POS_MIN) sentido_d = SENTIDO_SOBE;
         end
      end
   end

   always_comb begin
      posicao     = posicao_q;
      fim_posicao = (estado_q == PASSO) && !manual_ativo;
      db_sentido  = sentido_q;
      db_estado   = estado_q;
   end

endmodule

// File: tb/tb_sequenciador_posicao_servo.sv
// Directed self-checking bench for sequenciador_posicao_servo (TEMPO_POSICAO=10).
// Manual-override steps are compiled in only when POSICAO_MANUAL_EN is defined.
module tb_sequenciador_posicao_servo;

   logic       clock;
   logic       reset;
   logic       ligar;
   logic       zerar;
`ifdef POSICAO_MANUAL_EN
   logic       manual;
   logic [2:0] posicao_manual;
`endif
   logic [2:0] posicao;
   logic       fim_posicao;
   logic       db_sentido;
   logic [1:0] db_estado;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   sequenciador_posicao_servo #(
      .TEMPO_POSICAO (10),
      .W_TIMER       (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ligar          (ligar),
      .zerar          (zerar),
`ifdef POSICAO_MANUAL_EN
      .manual         (manual),
      .posicao_manual (posicao_manual),
`endif
      .posicao        (posicao),
      .fim_posicao    (fim_posicao),
      .db_sentido     (db_sentido),
      .db_estado      (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full dwell starting right after an update (or the ligar edge): 9 held
   // cycles with the PASSO pulse in the 9th, then the new code after the 10th edge.
   task automatic dwell(input logic [2:0] cur, input logic [2:0] nxt, input logic dir);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (fim_posicao === 1'b1) n_pulses++;
         if (c < 10) begin
            chk("hold", {29'd0, posicao}, {29'd0, cur});
            chk("fim", {31'd0, fim_posicao}, {31'd0, (c == 9)});
         end else begin
            chk("step", {29'd0, posicao}, {29'd0, nxt});
            chk("fim_after", {31'd0, fim_posicao}, 32'd0);
            chk("sentido", {31'd0, db_sentido}, {31'd0, dir});
         end
      end
   endtask

   logic [2:0] seq_pos [15];
   logic       seq_dir [15];

   initial begin
      seq_pos = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                  3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
      seq_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      reset = 1'b0;
      ligar = 1'b0;
      zerar = 1'b0;
`ifdef POSICAO_MANUAL_EN
      manual         = 1'b0;
      posicao_manual = 3'd0;
`endif
      #3;
      chk("rst_pos", {29'd0, posicao}, 32'd0);
      chk("rst_fim", {31'd0, fim_posicao}, 32'd0);
      chk("rst_estado", {30'd0, db_estado}, 32'd0);
      chk("rst_sentido", {31'd0, db_sentido}, 32'd0);

      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("idle_estado", {30'd0, db_estado}, 32'd0);

      // Full sweep 0 -> 7 -> 0 -> 1
      ligar = 1'b1;
      tick();
      chk("start_estado", {30'd0, db_estado}, 32'd1);
      chk("start_pos", {29'd0, posicao}, 32'd0);
      dwell(3'd0, seq_pos[0], seq_dir[0]);
      for (int s = 1; s < 15; s++) dwell(seq_pos[s-1], seq_pos[s], seq_dir[s]);
      chk("pulse_count", n_pulses, 32'd15);

      // Pause at 3 (up), four cycles into the dwell
      dwell(3'd1, 3'd2, 1'b0);
      dwell(3'd2, 3'd3, 1'b0);
      for (int c = 0; c < 4; c++) tick();
      ligar = 1'b0;
      tick();
      chk("pause_estado", {30'd0, db_estado}, 32'd0);
      for (int c = 0; c < 15; c++) tick();
      chk("pause_pos", {29'd0, posicao}, 32'd3);
      chk("pause_fim", {31'd0, fim_posicao}, 32'd0);
      ligar = 1'b1;
      tick();
      chk("resume_estado", {30'd0, db_estado}, 32'd1);
      dwell(3'd3, 3'd4, 1'b0);

      // zerar collides with the PASSO of 6 -> 5
      dwell(3'd4, 3'd5, 1'b0);
      dwell(3'd5, 3'd6, 1'b0);
      dwell(3'd6, 3'd7, 1'b1);
      dwell(3'd7, 3'd6, 1'b1);
      for (int c = 0; c < 9; c++) tick();
      chk("coll_passo", {30'd0, db_estado}, 32'd2);
      chk("coll_fim", {31'd0, fim_posicao}, 32'd1);
      zerar = 1'b1;
      tick();
      zerar = 1'b0;
      chk("zerar_pos", {29'd0, posicao}, 32'd0);
      chk("zerar_sentido", {31'd0, db_sentido}, 32'd0);
      chk("zerar_estado", {30'd0, db_estado}, 32'd1);
      dwell(3'd0, 3'd1, 1'b0);

      // Asynchronous reset mid-cycle at posicao 5
      dwell(3'd1, 3'd2, 1'b0);
      dwell(3'd2, 3'd3, 1'b0);
      dwell(3'd3, 3'd4, 1'b0);
      dwell(3'd4, 3'd5, 1'b0);
      tick();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("async_pos", {29'd0, posicao}, 32'd0);
      chk("async_fim", {31'd0, fim_posicao}, 32'd0);
      chk("async_estado", {30'd0, db_estado}, 32'd0);
      chk("async_sentido", {31'd0, db_sentido}, 32'd0);

`ifdef POSICAO_MANUAL_EN
      tick();
      reset          = 1'b1;
      ligar          = 1'b0;
      manual         = 1'b1;
      posicao_manual = 3'd7;
      tick();
      chk("man_pos", {29'd0, posicao}, 32'd7);
      chk("man_fim", {31'd0, fim_posicao}, 32'd0);
      tick();
      chk("man_fim2", {31'd0, fim_posicao}, 32'd0);
      chk("man_sentido", {31'd0, db_sentido}, 32'd1);
      manual = 1'b0;
      ligar  = 1'b1;
      tick();
      dwell(3'd7, 3'd6, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
